pipeline_ctrl: RTL

Parametrised hazard and pipeline-control unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Keeps a mirror scoreboard of in-flight destination registers.
- Generates operand-forwarding selects, load-use interlocks, branch flushes, and bus-wait freezes with timeout.
- Sits beside the stage modules in the core top. It drives their stall/flush/bubble inputs and the EX operand muxes.
- Adds hazard safety that the current free-running pipeline lacks.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/bus_wait_timer.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline control unit: forwarding-select encodings,
// scoreboard entry layouts and the register-match helpers used by pipeline_ctrl.
package pipe_pkg;

    localparam int DEFAULT_REG_AW = 5;
    // Widest register address the scoreboard entries can hold; narrower ids are zero-extended.
    localparam int SB_AW = 8;

    typedef logic [SB_AW-1:0] sb_reg_t;

    typedef enum logic [1:0] {
        FWD_ID  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_RET = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic    valid;
        sb_reg_t rd;
        logic    we;
    } sb_entry_t;

    typedef struct packed {
        logic    is_load;
        sb_reg_t rs1;
        sb_reg_t rs2;
        logic    rs1_used;
        logic    rs2_used;
    } ex_src_t;

    function automatic logic sb_hit(sb_entry_t e, sb_reg_t src, logic used);
        return e.valid && e.we && (e.rd != '0) && (e.rd == src) && used;
    endfunction

    // Youngest producer wins: MEM, then WB, then the retired-write buffer.
    function automatic fwd_sel_e fwd_select(sb_entry_t mem, sb_entry_t wb, sb_entry_t ret,
                                            sb_reg_t src, logic used);
        if (sb_hit(mem, src, used)) return FWD_MEM;
        if (sb_hit(wb, src, used))  return FWD_WB;
        if (sb_hit(ret, src, used)) return FWD_RET;
        return FWD_ID;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the core stages (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if #(
    parameter int REG_AW = pipe_pkg::DEFAULT_REG_AW
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_we;
    logic              id_is_load;
    logic              ex_redirect;
    logic              bus_req;
    logic              bus_ack;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              flush_if;
    logic              bubble_ex;
    logic              bubble_wb;
    logic [1:0]        fwd_rs1_sel;
    logic [1:0]        fwd_rs2_sel;
    logic              bus_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_we,
               id_is_load, ex_redirect, bus_req, bus_ack,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_if, bubble_ex, bubble_wb,
               fwd_rs1_sel, fwd_rs2_sel, bus_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_we,
               id_is_load, ex_redirect, bus_req, bus_ack,
        output stall_if, stall_id, stall_ex, stall_mem, flush_if, bubble_ex, bubble_wb,
               fwd_rs1_sel, fwd_rs2_sel, bus_err
    );
endinterface

// File: rtl/bus_wait_timer.sv
// MEM-stage bus wait tracker: raises hold while an access is outstanding and
// force-completes it on its BUS_TIMEOUT-th waiting cycle, pulsing bus_err one cycle later.
module bus_wait_timer #(
    parameter int BUS_TIMEOUT = 16,
    parameter int TO_W        = $clog2(BUS_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bus_req,
    input  logic bus_ack,
    output logic hold,
    output logic bus_err
);
    localparam logic [TO_W-1:0] LAST = TO_W'(BUS_TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            waiting, timeout;

    always_comb begin
        waiting   = bus_req & ~bus_ack;
        timeout   = waiting & (cnt_q == LAST);
        hold      = waiting & ~timeout;
        cnt_d     = hold ? cnt_q + TO_W'(1) : '0;
        bus_err_d = timeout;
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32I core.
// Operand forwarding is built only when PIPE_CTRL_FWD_EN is defined; otherwise hazards interlock.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = DEFAULT_REG_AW,
    parameter int BUS_TIMEOUT = 16,
    parameter int TO_W        = $clog2(BUS_TIMEOUT + 1)
) (
    input logic            clk,
    input logic            rst_n,
    pipeline_ctrl_if.slave pif
);
    sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, ret_q, ret_d;
    sb_entry_t id_ent;
    sb_reg_t   id_rs1, id_rs2;
    logic      hold, hazard;
    logic      stall_fe, bubble_ex, flush_if;
    fwd_sel_e  fwd_rs1, fwd_rs2;

    bus_wait_timer #(
        .BUS_TIMEOUT(BUS_TIMEOUT),
        .TO_W       (TO_W)
    ) u_bus_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_req(pif.bus_req),
        .bus_ack(pif.bus_ack),
        .hold   (hold),
        .bus_err(pif.bus_err)
    );

    always_comb begin
        id_rs1 = sb_reg_t'(pif.id_rs1);
        id_rs2 = sb_reg_t'(pif.id_rs2);
        id_ent = '{valid: pif.id_valid, rd: sb_reg_t'(pif.id_rd), we: pif.id_reg_we};
    end

`ifdef PIPE_CTRL_FWD_EN
    ex_src_t exs_q, exs_d;

    always_comb begin
        hazard  = pif.id_valid & exs_q.is_load &
                  (sb_hit(ex_q, id_rs1, pif.id_rs1_used) | sb_hit(ex_q, id_rs2, pif.id_rs2_used));
        fwd_rs1 = fwd_select(mem_q, wb_q, ret_q, exs_q.rs1, exs_q.rs1_used);
        fwd_rs2 = fwd_select(mem_q, wb_q, ret_q, exs_q.rs2, exs_q.rs2_used);
        exs_d   = exs_q;
        if (!hold) begin
            exs_d = (bubble_ex | ~pif.id_valid) ? '0 :
                    '{is_load: pif.id_is_load, rs1: id_rs1, rs2: id_rs2,
                      rs1_used: pif.id_rs1_used, rs2_used: pif.id_rs2_used};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) exs_q <= '0;
        else        exs_q <= exs_d;
    end
`else
    // Without forwarding, ID waits until no in-flight or just-retired write targets its sources.
    always_comb begin
        hazard  = pif.id_valid &
                  (sb_hit(ex_q,  id_rs1, pif.id_rs1_used) | sb_hit(ex_q,  id_rs2, pif.id_rs2_used) |
                   sb_hit(mem_q, id_rs1, pif.id_rs1_used) | sb_hit(mem_q, id_rs2, pif.id_rs2_used) |
                   sb_hit(wb_q,  id_rs1, pif.id_rs1_used) | sb_hit(wb_q,  id_rs2, pif.id_rs2_used) |
                   sb_hit(ret_q, id_rs1, pif.id_rs1_used) | sb_hit(ret_q, id_rs2, pif.id_rs2_used));
        fwd_rs1 = FWD_ID;
        fwd_rs2 = FWD_ID;
    end

    logic unused_is_load;
    assign unused_is_load = pif.id_is_load;
`endif

    // NOTE: every output gets a default before the priority chain, so no latch can be inferred.
    always_comb begin
        stall_fe  = 1'b0;
        bubble_ex = 1'b0;
        flush_if  = 1'b0;
        if (hold) begin
            stall_fe = 1'b1;
        end else if (pif.ex_redirect) begin
            flush_if  = 1'b1;
            bubble_ex = 1'b1;
        end else if (hazard) begin
            stall_fe  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!hold) begin
            ex_d  = (bubble_ex | ~pif.id_valid) ? '0 : id_ent;
            mem_d = ex_q;
        end
        wb_d  = hold ? '0 : mem_q;
        ret_d = wb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            ret_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            ret_q <= ret_d;
        end
    end

    assign pif.stall_if    = stall_fe;
    assign pif.stall_id    = stall_fe;
    assign pif.stall_ex    = hold;
    assign pif.stall_mem   = hold;
    assign pif.bubble_wb   = hold;
    assign pif.flush_if    = flush_if;
    assign pif.bubble_ex   = bubble_ex;
    assign pif.fwd_rs1_sel = fwd_rs1;
    assign pif.fwd_rs2_sel = fwd_rs2;
endmodule
